// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// uart_rx_if : serial line, frame setup and received-byte bundle for uart_rx
// Rev 1.0
// ============================================================================
interface uart_rx_if;
   logic       rxd;
   logic [1:0] parity_mode;
   logic [7:0] data_out;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   modport master (
      output rxd, parity_mode,
      input  data_out, rx_valid, parity_err, frame_err, busy
   );

   modport slave (
      input  rxd, parity_mode,
      output data_out, rx_valid, parity_err, frame_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1/8E1/8O1 UART receiver with 2-flop line synchroniser
// Rev 1.0
// ============================================================================
module uart_rx #(
   parameter int CLKS_PER_BIT = 1
) (
   input wire      clk,
   input wire      rst_n,
   uart_rx_if.slave bus
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
   localparam int MID   = (CLKS_PER_BIT - 1) / 2;
   localparam logic [CNT_W-1:0] C_LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] C_MID      = CNT_W'(MID);
   localparam logic [CNT_W-1:0] C_AFTER_T0 = (CLKS_PER_BIT == 1) ? '0 : CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_WAIT_IDLE = 3'd5
   } state_t;

   state_t           state;
   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shreg;
   logic [1:0]       mode;
   logic             par_err_q;

   logic rxd_s;
   logic sample;
   logic par_en;

   assign rxd_s  = sync[1];
   assign sample = (cnt == C_MID);
   assign par_en = mode[0] ^ mode[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync           <= 2'b11;
         state          <= S_IDLE;
         cnt            <= '0;
         bit_cnt        <= '0;
         shreg          <= '0;
         mode           <= '0;
         par_err_q      <= 1'b0;
         bus.data_out   <= '0;
         bus.rx_valid   <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.busy       <= 1'b0;
      end else begin
         sync         <= {sync[0], bus.rxd};
         bus.rx_valid <= 1'b0;
         cnt          <= (cnt == C_LAST) ? '0 : cnt + CNT_W'(1);

         case (state)
            S_IDLE: begin
               // The detection cycle is phase 0 of the start bit.
               cnt <= C_AFTER_T0;
               if (!rxd_s) begin
                  mode     <= bus.parity_mode;
                  bus.busy <= 1'b1;
                  bit_cnt  <= '0;
                  // With a zero mid-point the start sample is this very cycle.
                  state    <= (C_MID == '0) ? S_DATA : S_START;
               end
            end

            S_START: begin
               if (sample) begin
                  if (rxd_s) begin
                     state    <= S_IDLE;
                     bus.busy <= 1'b0;
                  end else begin
                     state <= S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (sample) begin
                  shreg   <= {rxd_s, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= par_en ? S_PARITY : S_STOP;
                  end
               end
            end

            S_PARITY: begin
               if (sample) begin
                  // Odd mode (10) inverts the sense of the even check.
                  par_err_q <= (^shreg) ^ rxd_s ^ mode[1];
                  state     <= S_STOP;
               end
            end

            S_STOP: begin
               if (sample) begin
                  bus.data_out   <= shreg;
                  bus.parity_err <= par_en & par_err_q;
                  bus.frame_err  <= ~rxd_s;
                  bus.rx_valid   <= 1'b1;
                  if (rxd_s) begin
                     state    <= S_IDLE;
                     bus.busy <= 1'b0;
                  end else begin
                     state <= S_WAIT_IDLE;
                  end
               end
            end

            S_WAIT_IDLE: begin
               if (rxd_s) begin
                  state    <= S_IDLE;
                  bus.busy <= 1'b0;
               end
            end

            default: begin
               state    <= S_IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : scoreboard bench for uart_rx at 1 and 16 clocks per bit
// Rev 1.0
// ============================================================================
module tb_uart_rx;

   localparam int CLK_NS = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #(CLK_NS / 2) clk = ~clk;

   uart_rx_if if1 ();
   uart_rx_if if16 ();

   uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if1.slave)
   );

   uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if16.slave)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } resp_t;

   resp_t  q1[$];
   resp_t  q16[$];
   longint vt16[$];
   resp_t  e1, e16;
   int     checks = 0;
   int     errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Parity bit a correct transmitter would send for this byte and mode.
   function automatic logic good_parity(input logic [7:0] d, input logic [1:0] m);
      int ones;
      ones = $countones(d);
      return (m == 2'b01) ? logic'(ones % 2) : logic'(1 - (ones % 2));
   endfunction

   function automatic resp_t model(input logic [7:0] d, input logic [1:0] m,
                                   input logic pbit, input logic stop);
      resp_t r;
      r.data = d;
      r.ferr = !stop;
      if (m == 2'b01 || m == 2'b10) r.perr = (pbit != good_parity(d, m));
      else                          r.perr = 1'b0;
      return r;
   endfunction

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (rst_n && if1.rx_valid === 1'b1) begin
         if (q1.size() == 0) begin
            chk("dut1 unexpected rx_valid", 32'd1, 32'd0);
         end else begin
            e1 = q1.pop_front();
            chk("dut1 data_out", 32'(if1.data_out), 32'(e1.data));
            chk("dut1 parity_err", 32'(if1.parity_err), 32'(e1.perr));
            chk("dut1 frame_err", 32'(if1.frame_err), 32'(e1.ferr));
            chk("dut1 busy at valid", 32'(if1.busy), 32'(e1.ferr));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && if16.rx_valid === 1'b1) begin
         vt16.push_back($time);
         if (q16.size() == 0) begin
            chk("dut16 unexpected rx_valid", 32'd1, 32'd0);
         end else begin
            e16 = q16.pop_front();
            chk("dut16 data_out", 32'(if16.data_out), 32'(e16.data));
            chk("dut16 parity_err", 32'(if16.parity_err), 32'(e16.perr));
            chk("dut16 frame_err", 32'(if16.frame_err), 32'(e16.ferr));
            chk("dut16 busy at valid", 32'(if16.busy), 32'(e16.ferr));
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic set_line(input bit sel16, input logic b);
      if (sel16) if16.rxd = b;
      else       if1.rxd  = b;
   endtask

   task automatic set_mode(input bit sel16, input logic [1:0] m);
      if (sel16) if16.parity_mode = m;
      else       if1.parity_mode  = m;
   endtask

   task automatic drive_bit(input bit sel16, input logic b);
      set_line(sel16, b);
      repeat (sel16 ? 16 : 1) @(negedge clk);
   endtask

   task automatic idle(input bit sel16, input int n);
      set_line(sel16, 1'b1);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the line at the stop value; the caller decides the idle gap.
   task automatic send(input bit sel16, input logic [7:0] d, input logic [1:0] m,
                       input logic pbit, input logic stop);
      if (sel16) q16.push_back(model(d, m, pbit, stop));
      else       q1.push_back(model(d, m, pbit, stop));
      set_mode(sel16, m);
      drive_bit(sel16, 1'b0);
      for (int i = 0; i < 8; i++) begin
         drive_bit(sel16, d[i]);
         if (i == 3) set_mode(sel16, 2'($urandom_range(0, 3)));
      end
      if (m == 2'b01 || m == 2'b10) drive_bit(sel16, pbit);
      drive_bit(sel16, stop);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q1.size() != 0 || q16.size() != 0) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard drained", 32'(q1.size() + q16.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] d;
      logic [1:0] m;
      logic       pb, st;
      bit         s16;
      int         gap;

      if1.rxd = 1'b1;  if1.parity_mode = 2'b00;
      if16.rxd = 1'b1; if16.parity_mode = 2'b00;

      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if1.rxd  = logic'(i % 2);
         if16.rxd = logic'((i + 1) % 2);
      end
      @(negedge clk);
      if1.rxd = 1'b1; if16.rxd = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset data_out", 32'(if1.data_out), 32'h0);
      chk("reset parity_err", 32'(if1.parity_err), 32'h0);
      chk("reset frame_err", 32'(if1.frame_err), 32'h0);
      chk("reset busy", 32'(if1.busy), 32'h0);
      chk("reset rx_valid", 32'(if1.rx_valid), 32'h0);
      chk("reset16 data_out", 32'(if16.data_out), 32'h0);
      chk("reset16 busy", 32'(if16.busy), 32'h0);
      repeat (5) @(negedge clk);
      chk("idle after reset busy", 32'(if1.busy | if16.busy), 32'h0);

      // directed frames at one clock per bit
      send(0, 8'hA3, 2'b00, 1'b0, 1'b1); idle(0, 3);
      send(0, 8'hFF, 2'b11, 1'b0, 1'b1); idle(0, 3);
      send(0, 8'hF4, 2'b01, 1'b1, 1'b1); idle(0, 3);
      send(0, 8'hF4, 2'b01, 1'b0, 1'b1); idle(0, 3);
      send(0, 8'h4F, 2'b10, 1'b0, 1'b1); idle(0, 3);
      drain();

      // stop bit low followed by a held-low line
      send(0, 8'h3C, 2'b00, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("busy while line low", 32'(if1.busy), 32'h1);
      idle(0, 6);
      chk("busy after line high", 32'(if1.busy), 32'h0);
      chk("data_out held", 32'(if1.data_out), 32'h3C);
      chk("frame_err held", 32'(if1.frame_err), 32'h1);
      drain();

      // back-to-back frames with no idle gap
      vt16.delete();
      send(1, 8'h55, 2'b00, 1'b0, 1'b1);
      send(1, 8'hAA, 2'b00, 1'b0, 1'b1);
      idle(1, 20);
      drain();
      chk("b2b valid count", 32'(vt16.size()), 32'd2);
      if (vt16.size() == 2)
         chk("b2b valid spacing", 32'(vt16[1] - vt16[0]), 32'(160 * CLK_NS));

      // short low glitch
      if16.rxd = 1'b0;
      repeat (3) @(negedge clk);
      if16.rxd = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch busy seen", 32'(if16.busy), 32'h1);
      repeat (40) @(negedge clk);
      chk("glitch back to idle", 32'(if16.busy), 32'h0);

      // reset in the middle of a frame
      if16.rxd = 1'b0;
      repeat (40) @(negedge clk);
      chk("midframe busy", 32'(if16.busy), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("midframe reset busy", 32'(if16.busy), 32'h0);
      chk("midframe reset data", 32'(if16.data_out), 32'h0);
      if16.rxd = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // randomized frames on both instances
      for (int i = 0; i < 40; i++) begin
         s16 = ($urandom_range(0, 1) == 1);
         d   = 8'($urandom);
         m   = 2'($urandom_range(0, 3));
         pb  = good_parity(d, m) ^ ($urandom_range(0, 3) == 0);
         st  = ($urandom_range(0, 7) != 0);
         send(s16, d, m, pb, st);
         gap = st ? $urandom_range(0, 3) * (s16 ? 16 : 1) : 3 * (s16 ? 16 : 1) + 4;
         idle(s16, gap);
      end
      idle(0, 20);
      idle(1, 20);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1/8E1/8O1 UART receiver, the receive-side counterpart of the team's UART transmitter.
- Frame format matches the transmitter: start(0), 8 data bits LSB first, optional parity, stop(1).
- Parity encoding matches the transmitter's PARITY_MODE.
- Synchronises the serial line, validates start/parity/stop, and presents each byte with a one-cycle RX_VALID pulse and error flags.

Parameters:
CLKS_PER_BIT, 1, clock cycles per serial bit; legal values >= 1. Default 1 matches the transmitter's one-bit-per-clock rate.

Ports:
CLK  input  1  system clock, all logic on rising edge
RST_N  input  1  reset; asynchronous assert, active-low
RXD  input  1  serial line, idle high
PARITY_MODE  input  2  00 none, 01 even, 10 odd, 11 none
DATA_OUT  output  8  last received byte
RX_VALID  output  1  one-cycle pulse: DATA_OUT and error flags updated
PARITY_ERR  output  1  parity mismatch on last frame (held)
FRAME_ERR  output  1  stop bit sampled 0 on last frame (held)
BUSY  output  1  high while a frame is being received

Behaviour:
- Reset (RST_N=0, async):
  - DATA_OUT=8'h00; RX_VALID, PARITY_ERR, FRAME_ERR and BUSY = 0.
  - Both synchroniser flops = 1.
  - FSM = IDLE, counters = 0.
- Synchroniser: RXD passes through 2 flops to give rxd_s (2-cycle latency). All FSM decisions use rxd_s only.
- Sample point: MID = (CLKS_PER_BIT-1)/2, integer division.
  - Define cycle T0 as the IDLE cycle in which rxd_s==0 is seen.
  - Bit k is sampled at T0 + k*CLKS_PER_BIT + MID.
  - k=0 is the start bit, k=1..8 are data bits LSB first, k=9 is parity when enabled, then the stop bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: at T0, latch PARITY_MODE into an internal register (frame uses the latched value), set BUSY=1, go to START. PARITY_MODE changes mid-frame are ignored.
  - START: at the k=0 sample:
    - rxd_s==1: glitch, return to IDLE, BUSY=0, no RX_VALID.
    - otherwise: go to DATA.
    - With CLKS_PER_BIT=1 the k=0 sample is T0 itself, so it always passes.
  - DATA: shift 8 samples LSB-first into the shift register; 3-bit bit counter; then go to PARITY if the latched mode is 01/10, else STOP.
  - PARITY: sample one bit. Error if (XOR of data ^ sampled bit) != 0 for even, or == 0 for odd.
  - STOP: at the stop sample:
    - Next cycle: DATA_OUT <= shift register, PARITY_ERR and FRAME_ERR updated, RX_VALID=1 for exactly one cycle.
    - PARITY_ERR is forced 0 when the latched mode is 00/11.
    - Stop sampled 1: go to IDLE, BUSY=0 in the same cycle as RX_VALID.
    - Stop sampled 0: go to WAIT_IDLE.
  - WAIT_IDLE: BUSY stays 1 until rxd_s==1, then go to IDLE. This prevents a break or low line from being taken as a new start bit.
- Back-to-back frames: a start bit immediately after the stop bit (zero idle gap) must be received. Leaving STOP for IDLE costs no extra sample.
- Bit timing counter: width $clog2(CLKS_PER_BIT)+1; wraps to 0 at CLKS_PER_BIT-1 within each bit.
- Held outputs: DATA_OUT and the error flags keep their value until the next RX_VALID; the flags are not sticky across frames.
- Reset mid-frame: immediate return to reset values; no RX_VALID for the partial frame.

Test Plan:
- Reset: RST_N=0 with RXD toggling for 5 cycles, then release with RXD=1 -> all outputs 0, BUSY=0, no RX_VALID.
- No parity, CLKS_PER_BIT=1, PARITY_MODE=00: drive frame 8'hA3 (0,1,1,0,0,0,1,0,1,1) -> exactly one RX_VALID pulse, DATA_OUT=8'hA3, PARITY_ERR=0, FRAME_ERR=0.
- Same with PARITY_MODE=11 and byte 8'hFF -> treated as no parity, DATA_OUT=8'hFF, 10-bit frame.
- Even parity, byte 8'hF4, parity bit 1 -> DATA_OUT=8'hF4, PARITY_ERR=0. Repeat with parity bit 0 -> PARITY_ERR=1, RX_VALID still pulses.
- Odd parity, byte 8'h4F, parity bit 0 -> DATA_OUT=8'h4F, PARITY_ERR=0.
- Stop bit driven 0 then line held low 20 cycles -> FRAME_ERR=1, single RX_VALID, BUSY=1 until line high, no second frame.
- Back-to-back 8'h55 then 8'hAA, zero idle gap, CLKS_PER_BIT=16 -> two RX_VALID pulses exactly 160 cycles apart with the correct data.
- Glitch: with CLKS_PER_BIT=16, a 3-cycle low pulse on RXD -> returns to IDLE, no RX_VALID.
